// File: rtl/ex_muldiv_unit_pkg.sv
// Shared encodings for the EX-stage iterative multiply/divide unit.
package ex_muldiv_unit_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } md_state_e;

  // Wide enough for any supported WIDTH; users take the low WIDTH bits.
  localparam logic [63:0] DIV0_LO = '1;

  // Bit 0 of the opcode marks the unsigned variants.
  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Accumulator and one radix-2 step per cycle: shift-add multiply or restoring divide.
module muldiv_datapath #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic               is_div,
  input  logic [WIDTH-1:0]   mag_a,
  input  logic [WIDTH-1:0]   mag_b,
  output logic [2*WIDTH-1:0] acc
);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q;
  logic               is_div_q;
  logic [WIDTH:0]     sum, r_sh, diff;

  // Multiply: acc = {partial, multiplier}; divide: acc = {remainder, quotient/dividend}.
  always_comb begin
    sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
    r_sh  = acc_q[2*WIDTH-1:WIDTH-1];
    diff  = r_sh - {1'b0, opnd_q};
    acc_d = acc_q;
    if (load) begin
      acc_d = {{WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
    end else if (step) begin
      if (is_div_q) begin
        if (!diff[WIDTH]) acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        else              acc_d = {r_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end else if (acc_q[0]) begin
        acc_d = {sum, acc_q[WIDTH-1:1]};
      end else begin
        acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q    <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      if (load) begin
        opnd_q   <= is_div ? mag_b : mag_a;
        is_div_q <= is_div;
      end
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage mul/div unit: sequencing FSM, architectural HI/LO and the pipeline stall request.
module ex_muldiv_unit
  import ex_muldiv_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             mthi_we,
  input  logic             mtlo_we,
  input  logic             hl_read,
  input  logic             flush,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall_req
);

  localparam int unsigned CntW = $clog2(WIDTH);

  md_state_e          state_q;
  logic [CntW-1:0]    cnt_q;
  logic               is_div_q, neg_res_q, neg_rem_q, div0_q;
  logic [WIDTH-1:0]   a_raw_q, hi_q, lo_q;

  logic               a_neg, b_neg, load;
  logic [WIDTH-1:0]   mag_a, mag_b, quo, rem;
  logic [2*WIDTH-1:0] acc, prod;
  logic [WIDTH-1:0]   hi_res, lo_res;

  always_comb begin
    a_neg = op_is_signed(op) & src_a[WIDTH-1];
    b_neg = op_is_signed(op) & src_b[WIDTH-1];
    mag_a = a_neg ? -src_a : src_a;
    mag_b = b_neg ? -src_b : src_b;
    load  = (state_q == StIdle) & start & ~flush;
  end

  muldiv_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .step  (state_q == StRun),
    .is_div(op[1]),
    .mag_a (mag_a),
    .mag_b (mag_b),
    .acc   (acc)
  );

  // Sign correction applied while in StDone, committed on the edge leaving it.
  always_comb begin
    prod = neg_res_q ? -acc : acc;
    quo  = acc[WIDTH-1:0];
    rem  = acc[2*WIDTH-1:WIDTH];
    if (!is_div_q) begin
      hi_res = prod[2*WIDTH-1:WIDTH];
      lo_res = prod[WIDTH-1:0];
    end else if (div0_q) begin
      hi_res = a_raw_q;
      lo_res = DIV0_LO[WIDTH-1:0];
    end else begin
      hi_res = neg_rem_q ? -rem : rem;
      lo_res = neg_res_q ? -quo : quo;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      a_raw_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (!flush) begin
            if (start) begin
              state_q   <= StRun;
              cnt_q     <= '0;
              is_div_q  <= op[1];
              neg_res_q <= a_neg ^ b_neg;
              neg_rem_q <= a_neg;
              div0_q    <= op[1] & (src_b == '0);
              a_raw_q   <= src_a;
            end else begin
              if (mthi_we) hi_q <= src_a;
              if (mtlo_we) lo_q <= src_a;
            end
          end
        end
        StRun: begin
          if (flush) begin
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CntW'(WIDTH - 1)) state_q <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
          if (!flush) begin
            hi_q <= hi_res;
            lo_q <= lo_res;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign hi        = hi_q;
  assign lo        = lo_q;
  assign busy      = (state_q != StIdle);
  assign stall_req = busy & (start | hl_read | mthi_we | mtlo_we);

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit with a HI/LO scoreboard and immediate-assertion checks.
module tb_ex_muldiv_unit;
  import ex_muldiv_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a, src_b;
  logic        mthi_we, mtlo_we, hl_read, flush;
  logic [31:0] hi, lo;
  logic        busy, stall_req;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  ex_muldiv_unit #(
    .WIDTH(32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .mthi_we  (mthi_we),
    .mtlo_we  (mtlo_we),
    .hl_read  (hl_read),
    .flush    (flush),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy),
    .stall_req(stall_req)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one start pulse; returns at the negedge after the sampling edge.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op    = o;
    src_a = a;
    src_b = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait (bounded) for busy to drop, then compare HI/LO with the scoreboard head.
  task automatic finish_op(input string tag, input int exp_cycles);
    int   n;
    exp_t e;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_busy_cycles"}, n, exp_cycles);
    e = sb.pop_front();
    check({tag, "_hi"}, hi, e.hi);
    check({tag, "_lo"}, lo, e.lo);
  endtask

  task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    sb.push_back('{hi: ehi, lo: elo});
    issue(o, a, b);
    finish_op(tag, 33);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
    mthi_we = 1'b0; mtlo_we = 1'b0; hl_read = 1'b0; flush = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    rst = 1'b0;

    do_op("mult_neg3x5", OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);

    // MULTU with a second start while busy; the result must be the first operation's.
    sb.push_back('{hi: 32'h0000_0001, lo: 32'hFFFF_FFFE});
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
    repeat (3) @(negedge clk);
    op = OP_MULT; src_a = 32'd5; src_b = 32'd5; start = 1'b1;
    #1 check("busy_start_stall", stall_req, 1);
    @(negedge clk);
    start = 1'b0;
    finish_op("multu_ign_start", 29);

    do_op("div_neg7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    do_op("divu_by0", OP_DIVU, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF);
    do_op("div_min_m1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);

    // MULT 6x7 with a dependent MFHI/MFLO from cycle 3, independent at cycle 5.
    sb.push_back('{hi: 32'd0, lo: 32'd42});
    issue(OP_MULT, 32'd6, 32'd7);
    for (int j = 1; j <= 35; j++) begin
      hl_read = (j >= 3) && (j != 5);
      #1;
      check($sformatf("stall_c%0d", j), stall_req, (j <= 33) && hl_read);
      check($sformatf("busy_c%0d", j), busy, (j <= 33));
      @(negedge clk);
    end
    hl_read = 1'b0;
    finish_op("mult_6x7", 0);

    // MTHI/MTLO preload, then a flushed DIV leaves them intact.
    @(negedge clk); mthi_we = 1'b1; src_a = 32'h11;
    @(negedge clk); mthi_we = 1'b0; mtlo_we = 1'b1; src_a = 32'h22;
    @(negedge clk); mtlo_we = 1'b0;
    check("mthi", hi, 32'h11);
    check("mtlo", lo, 32'h22);
    issue(OP_DIV, 32'd100, 32'd3);
    for (int j = 1; j < 10; j++) begin
      start   = (j == 2);
      mthi_we = (j == 4);
      if (j == 2) begin op = OP_DIVU; src_a = 32'd9; src_b = 32'd9; end
      if (j == 4) src_a = 32'h99;
      #1;
      if (j == 2 || j == 4) check($sformatf("flushrun_stall_c%0d", j), stall_req, 1);
      @(negedge clk);
    end
    start = 1'b0; mthi_we = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", busy, 0);
    check("flush_hi", hi, 32'h11);
    check("flush_lo", lo, 32'h22);
    repeat (3) @(negedge clk);
    check("post_flush_busy", busy, 0);
    check("post_flush_hi", hi, 32'h11);

    // Start and MT writes in the same cycle: start wins, writes dropped.
    @(negedge clk);
    op = OP_MULTU; src_a = 32'h55; src_b = 32'd1; start = 1'b1;
    mthi_we = 1'b1; mtlo_we = 1'b1;
    @(negedge clk);
    start = 1'b0; mthi_we = 1'b0; mtlo_we = 1'b0;
    check("collide_busy", busy, 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("collide_hi", hi, 32'h11);
    check("collide_lo", lo, 32'h22);

    // Asynchronous reset mid-run.
    issue(OP_MULTU, 32'd3, 32'd4);
    repeat (14) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_hi", hi, 0);
    check("arst_lo", lo, 0);
    @(negedge clk);
    rst = 1'b0;
    do_op("post_rst_divu", OP_DIVU, 32'd9, 32'd2, 32'd1, 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
Iterative multiply/divide unit in the EX stage. It consumes operands and a decoded mul/div opcode from the ID/EX pipeline register, and owns the architectural HI/LO registers. It raises a stall request that the hazard unit turns into the ID/EX Stall inputs (bubble insertion) while an operation is in flight. It also serves MFHI/MFLO reads and MTHI/MTLO writes.

Parameters:
WIDTH, 32, operand/HI/LO width; the iteration count equals WIDTH.

Ports:
clk  in  1  clock
rst  in  1  reset
start  in  1  EX-stage instruction is MULT/MULTU/DIV/DIVU (already qualified by valid/non-bubble)
op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
src_a  in  WIDTH  rs operand (forwarded); multiplicand or dividend
src_b  in  WIDTH  rt operand (forwarded); multiplier or divisor
mthi_we  in  1  MTHI in EX
mtlo_we  in  1  MTLO in EX
hl_read  in  1  MFHI/MFLO in EX
flush  in  1  abort the in-flight operation (exception/redirect)
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register
busy  out  1  operation in flight
stall_req  out  1  hold the IF/ID/EX stages and inject an EX bubble

Behaviour:
- Reset is asynchronous and active-high: rst, clock clk. On rst: state=IDLE, hi=0, lo=0, busy=0, all internal accumulators, counter and sign flags=0.
- Reset mid-operation aborts immediately. HI/LO return to 0.
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN at the posedge where start=1 and flush=0.
  - Latch |src_a| and |src_b|. For signed ops, take the two's-complement magnitude; for unsigned ops, take the raw value.
  - Latch the result-sign and remainder-sign flags, the op, and the divide-by-zero flag (op[1] & src_b==0).
  - Set counter=0.
- RUN: one radix-2 step per cycle. Multiply uses shift-add into a 2*WIDTH product. Divide uses restoring shift-subtract producing quotient and remainder.
  - counter increments each cycle.
  - After step WIDTH-1 (counter==WIDTH-1), go to DONE.
- DONE (one cycle): sign-correct the result. At the posedge leaving DONE, write HI/LO and go to IDLE.
- Multiply result: {HI,LO} = product; negate the full 2*WIDTH product if the result sign is negative.
- Divide result: LO = quotient, negated if the operand signs differ. HI = remainder, taking the sign of the dividend.
- Divide by zero: HI = src_a as latched (original value), LO = all ones. No trap.
- Signed -2^31 / -1: LO=0x80000000, HI=0. This falls out of the magnitude path; no special case is needed.
- Latency: start sampled at edge 0 -> busy=1 after edge 0. HI/LO are updated and busy=0 after edge WIDTH+1 (edge 33 for WIDTH=32).
- busy = (state != IDLE).
- stall_req = busy & (start | hl_read | mthi_we | mtlo_we). This is combinational.
  - A dependent mul/div or HI/LO access waits.
  - Independent instructions proceed under the running operation.
- start while busy is ignored. stall_req holds that instruction in EX until IDLE.
- MTHI/MTLO: write src_a into HI/LO at the posedge when IDLE.
  - Ignored while busy; stall holds them.
  - If start and mt*_we are both asserted, start wins and the write is dropped.
- flush in RUN/DONE: go to IDLE at the next posedge, busy=0, and leave HI/LO unchanged.
- flush in IDLE suppresses that cycle's start and MT writes.
- hi/lo outputs are the registers directly. MFHI/MFLO read them in EX once stall_req is low.

Decomposition:
- Shared package holds: the op encodings (OP_MULT=2'b00, OP_MULTU=2'b01, OP_DIV=2'b10, OP_DIVU=2'b11), the state encodings (IDLE/RUN/DONE), and the DIV0_LO=all-ones constant.
- One natural sub-module, muldiv_datapath. It holds the accumulator/shift registers and the per-step add/subtract. The FSM, HI/LO registers and stall logic stay in ex_muldiv_unit.

Test Plan:
- MULT src_a=0xFFFFFFFD (-3), src_b=5 -> after 33 cycles hi=0xFFFFFFFF, lo=0xFFFFFFF1. busy high for exactly 33 cycles.
- MULTU 0xFFFFFFFF × 2 -> hi=0x00000001, lo=0xFFFFFFFE. Then DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 7 / 0 -> hi=7, lo=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- MULT 6×7 with hl_read asserted at cycle 3 -> stall_req=1 cycles 3..33, then hi=0, lo=42. An unrelated instruction (hl_read=0) at cycle 5 sees stall_req=0.
- Preload via MTHI 0x11, MTLO 0x22. Start DIV 100/3, assert flush at cycle 10 -> busy=0 next cycle, hi=0x11, lo=0x22 unchanged. A second start while busy is ignored.
- Assert rst asynchronously mid-RUN (cycle 15) -> busy, hi, lo = 0 immediately. A start after release completes normally.
